// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers: default sample width,
// signed sample type and the max/ReLU primitives.
package cnn_pkg;

   localparam int DEF_DATA_W = 15;
   localparam int WIDE_W     = 32;

   typedef logic signed [DEF_DATA_W-1:0] sample_t;
   typedef logic signed [WIDE_W-1:0]     wide_t;

   // Operands are sign-extended to wide_t so any DATA_W <= WIDE_W fits.
   // On a tie the first (stored) operand is kept.
   function automatic wide_t smax(input wide_t a, input wide_t b);
      return (b > a) ? b : a;
   endfunction

   function automatic wide_t relu(input wide_t a);
      return (a > 0) ? a : '0;
   endfunction

endpackage

// File: rtl/pool_chan_buf.sv
// One channel of the 2x2 pool: half-row max buffer, compare and ReLU.
// ReLU is applied only when MAXPOOL_RELU_EN is defined.
module pool_chan_buf
   import cnn_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 12,
   parameter int IDX_W  = 4
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic                     load,
   input  logic [IDX_W-1:0]         idx,
   input  logic signed [DATA_W-1:0] sample,
   output logic signed [DATA_W-1:0] pooled
);

   logic signed [DATA_W-1:0] mem [DEPTH];
   logic signed [DATA_W-1:0] held;
   logic signed [DATA_W-1:0] m;

   assign held = mem[idx];
   assign m    = DATA_W'(smax(wide_t'(held), wide_t'(sample)));

`ifdef MAXPOOL_RELU_EN
   assign pooled = DATA_W'(relu(wide_t'(m)));
`else
   assign pooled = m;
`endif

   // Contents are deliberately not reset; every window starts with a load.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= load ? sample : m;
      end
   end

endmodule

// File: rtl/maxpool2x2_relu_stream.sv
// 2x2 stride-2 max-pool (+ReLU with MAXPOOL_RELU_EN) over NUM_CH channels
// of a raster stream, with valid/ready, frame last and sync clear.
module maxpool2x2_relu_stream
   import cnn_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_CH    = 3,
   parameter int IN_WIDTH  = 24,
   parameter int IN_HEIGHT = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     out_last
);

   localparam int COL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
   localparam int DEPTH = IN_WIDTH / 2;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (IN_WIDTH % 2 != 0 || IN_HEIGHT % 2 != 0 || NUM_CH < 1) begin : g_bad_cfg
      $error("maxpool2x2_relu_stream: even IN_WIDTH/IN_HEIGHT and NUM_CH>=1 needed");
   end

   if (DATA_W > WIDE_W) begin : g_bad_w
      $error("maxpool2x2_relu_stream: DATA_W exceeds cnn_pkg::WIDE_W");
   end

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             col_last;
   logic             row_last;
   logic             acc;
   logic             fin;
   logic             buf_we;
   logic             buf_load;
   logic [IDX_W-1:0] idx;

   logic [NUM_CH*DATA_W-1:0] pooled;

   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;
   assign col_last = (col == COL_W'(IN_WIDTH - 1));
   assign row_last = (row == ROW_W'(IN_HEIGHT - 1));
   assign idx      = IDX_W'(col >> 1);

   // An aborted beat must not disturb the buffers either.
   assign buf_we   = acc && !clear;
   assign buf_load = !row[0] && !col[0];
   assign fin      = acc && row[0] && col[0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pool_chan_buf #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .IDX_W  (IDX_W)
      ) u_buf (
         .clk    (clk),
         .wr_en  (buf_we),
         .load   (buf_load),
         .idx    (idx),
         .sample (in_data[c*DATA_W +: DATA_W]),
         .pooled (pooled[c*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (clear) begin
         col       <= '0;
         row       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (acc) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         // A fresh result wins over the handshake that retires the old one.
         if (fin) begin
            out_valid <= 1'b1;
            out_data  <= pooled;
            out_last  <= row_last && col_last;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_maxpool2x2_relu_stream.sv
// Directed + reference-model bench for maxpool2x2_relu_stream
// (small 4x2x1 instance and a default 24x24x3 instance).
module tb_maxpool2x2_relu_stream;

   logic clk = 1'b0;
   logic rst_n;
   logic clear;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
   logic [14:0] s_in_data, s_out_data;

   logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_out_last;
   logic [44:0] f_in_data, f_out_data;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] s_q[$];
   logic [45:0] f_q[$];

   typedef struct {
      int px[8];
      int m0;
      int m1;
   } vec_t;

   vec_t vt[4];

   logic signed [14:0] img[2][24][24][3];

   always #5 clk = ~clk;

   maxpool2x2_relu_stream #(
      .DATA_W(15), .NUM_CH(1), .IN_WIDTH(4), .IN_HEIGHT(2)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_data(s_out_data), .out_last(s_out_last)
   );

   maxpool2x2_relu_stream dut_f (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
      .out_valid(f_out_valid), .out_ready(f_out_ready),
      .out_data(f_out_data), .out_last(f_out_last)
   );

   always @(negedge clk) begin
      if (rst_n && s_out_valid && s_out_ready)
         s_q.push_back({s_out_last, s_out_data});
      if (rst_n && f_out_valid && f_out_ready)
         f_q.push_back({f_out_last, f_out_data});
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [14:0] exp_v(input logic signed [14:0] m);
`ifdef MAXPOOL_RELU_EN
      if (m < 0) return '0;
`endif
      return m;
   endfunction

   function automatic logic [14:0] pool4(input logic signed [14:0] a, b, c, d);
      logic signed [14:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return exp_v(m);
   endfunction

   task automatic s_send(input int d);
      int n;
      n = 0;
      s_in_valid = 1'b1;
      s_in_data  = 15'(d);
      forever begin
         @(negedge clk);
         if (s_in_ready) break;
         n++;
         if (n > 200) begin
            n_chk++;
            $display("FAIL s_send_timeout: got stalled expected accept");
            break;
         end
      end
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
   endtask

   task automatic f_send(input logic [44:0] d);
      int n;
      n = 0;
      f_in_valid = 1'b1;
      f_in_data  = d;
      forever begin
         @(negedge clk);
         if (f_in_ready) break;
         n++;
         if (n > 200) begin
            n_chk++;
            $display("FAIL f_send_timeout: got stalled expected accept");
            break;
         end
      end
      @(posedge clk);
      #1;
      f_in_valid = 1'b0;
   endtask

   task automatic wait_s(input int n);
      for (int i = 0; i < 50 && s_q.size() < n; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("s_out_count", s_q.size(), n);
   endtask

   task automatic check_pair(input string nm, input int m0, input int m1);
      if (s_q.size() >= 2) begin
         chk({nm, "_d0"}, s_q[0][14:0], exp_v(15'(m0)));
         chk({nm, "_l0"}, s_q[0][15], 1'b0);
         chk({nm, "_d1"}, s_q[1][14:0], exp_v(15'(m1)));
         chk({nm, "_l1"}, s_q[1][15], 1'b1);
      end
   endtask

   initial begin
      logic        hold_ok;
      logic [14:0] d0;
      logic [44:0] pk;
      logic [45:0] ex;
      time         t0, t1;
      int          k;

      vt[0].px = '{3, -1, 7, 2, 5, 9, -4, 1};
      vt[0].m0 = 9;      vt[0].m1 = 7;
      vt[1].px = '{-5, -3, 4, -6, -8, -2, 0, -1};
      vt[1].m0 = -2;     vt[1].m1 = 4;
      vt[2].px = '{6, 6, -7, -7, 6, 6, -7, -7};
      vt[2].m0 = 6;      vt[2].m1 = -7;
      vt[3].px = '{16383, -16384, -16384, -16384, 0, 1, -16384, -1};
      vt[3].m0 = 16383;  vt[3].m1 = -1;

      rst_n = 1'b0;
      clear = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
      f_in_valid = 1'b0; f_in_data = '0; f_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", s_out_valid, 1'b0);
      chk("rst_out_data", s_out_data, 15'd0);
      chk("rst_out_last", s_out_last, 1'b0);
      chk("rst_in_ready", s_in_ready, 1'b1);
      chk("rst_f_out_valid", f_out_valid, 1'b0);
      @(posedge clk);
      #1;

      // table-driven 4x2 frames, out_ready held high
      for (int v = 0; v < 4; v++) begin
         s_q.delete();
         for (int i = 0; i < 8; i++) begin
            s_send(vt[v].px[i]);
            if (i == 4) chk("lat_early", s_out_valid, 1'b0);
            if (i == 5) chk("lat_valid", s_out_valid, 1'b1);
         end
         wait_s(2);
         check_pair($sformatf("vec%0d", v), vt[v].m0, vt[v].m1);
      end

      // backpressure after the first result
      s_q.delete();
      s_out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) s_send(vt[0].px[i]);
         end
         begin
            for (int i = 0; i < 50 && !s_out_valid; i++) @(negedge clk);
            d0 = s_out_data;
            hold_ok = s_out_valid;
            repeat (10) begin
               @(negedge clk);
               if (s_in_ready || !s_out_valid || s_out_data !== d0) hold_ok = 1'b0;
            end
            chk("bp_hold", hold_ok, 1'b1);
            chk("bp_data", d0, exp_v(15'sd9));
            @(posedge clk);
            #1 s_out_ready = 1'b1;
         end
      join
      wait_s(2);
      check_pair("bp", 9, 7);

      // async reset mid-row while a result is pending
      s_q.delete();
      s_out_ready = 1'b0;
      for (int i = 0; i < 6; i++) s_send(vt[0].px[i]);
      chk("pre_rst_valid", s_out_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", s_out_valid, 1'b0);
      chk("async_rst_data", s_out_data, 15'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      s_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) s_send(vt[0].px[i]);
      wait_s(2);
      check_pair("post_rst", 9, 7);

      // clear coinciding with an accepted beat, mid-frame
      s_q.delete();
      for (int i = 0; i < 3; i++) s_send(vt[0].px[i]);
      clear = 1'b1;
      s_in_valid = 1'b1;
      s_in_data = 15'd100;
      @(negedge clk);
      chk("clr_in_ready", s_in_ready, 1'b1);
      @(posedge clk);
      #1;
      clear = 1'b0;
      s_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("clr_no_out", s_out_valid, 1'b0);
      chk("clr_q_empty", s_q.size(), 0);
      for (int i = 0; i < 8; i++) s_send(vt[1].px[i]);
      wait_s(2);
      check_pair("post_clr", vt[1].m0, vt[1].m1);

      // two back-to-back 24x24x3 frames vs reference model
      for (int fr = 0; fr < 2; fr++)
         for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
               for (int ch = 0; ch < 3; ch++)
                  img[fr][r][c][ch] = 15'($urandom);
      f_q.delete();
      @(posedge clk);
      #1;
      t0 = $time;
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 24; c++) begin
            for (int ch = 0; ch < 3; ch++) pk[ch*15 +: 15] = img[0][r][c][ch];
            f_send(pk);
         end
      t1 = $time;
      chk("thruput_cycles", (t1 - t0) / 10, 576);
      fork
         begin
            for (int r = 0; r < 24; r++)
               for (int c = 0; c < 24; c++) begin
                  for (int ch = 0; ch < 3; ch++) pk[ch*15 +: 15] = img[1][r][c][ch];
                  f_send(pk);
               end
         end
         begin
            while (f_q.size() < 280) begin
               @(posedge clk);
               #1 f_out_ready = ($urandom_range(3) != 0);
            end
            f_out_ready = 1'b1;
         end
      join
      for (int i = 0; i < 200 && f_q.size() < 288; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("f_out_count", f_q.size(), 288);
      k = 0;
      for (int fr = 0; fr < 2; fr++)
         for (int wr = 0; wr < 12; wr++)
            for (int wc = 0; wc < 12; wc++) begin
               for (int ch = 0; ch < 3; ch++)
                  ex[ch*15 +: 15] = pool4(img[fr][2*wr][2*wc][ch],
                                          img[fr][2*wr][2*wc+1][ch],
                                          img[fr][2*wr+1][2*wc][ch],
                                          img[fr][2*wr+1][2*wc+1][ch]);
               ex[45] = (wr == 11 && wc == 11);
               if (k < f_q.size())
                  chk($sformatf("f_px%0d", k), f_q[k], ex);
               k++;
            end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
